// File: rtl/ifm_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ifm_buf_ctrl
// Brief   : Raster sequencer for the 4-entry IFM shift buffer; presents
//           per-row 4-pixel windows. IFM_CTRL_PERF_EN adds stall_cnt.
// Rev     : 1.0 - initial release
// ============================================================================
module ifm_buf_ctrl #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int CW    = $clog2(IMG_W),
   parameter int RW    = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              src_valid,
   input  logic signed [7:0] src_data,
   output logic              src_ready,
   output logic signed [7:0] ifm_input,
   output logic              ifm_read,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [CW-1:0]     win_col,
   output logic [RW-1:0]     win_row,
   output logic              busy,
   output logic              done
`ifdef IFM_CTRL_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   // col_cnt must reach IMG_W itself, so it is one value wider than a column index
   localparam int                c_CCW       = $clog2(IMG_W + 1);
   localparam logic [c_CCW-1:0]  c_COL_MAX   = c_CCW'(IMG_W);
   localparam logic [c_CCW-1:0]  c_COL_WIN   = c_CCW'(4);
   localparam logic [c_CCW-1:0]  c_COL_LFILL = c_CCW'(3);
   localparam logic [RW-1:0]     c_ROW_LAST  = RW'(IMG_H - 1);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_FILL  = 2'd1;
   localparam logic [1:0] c_ST_SLIDE = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   logic [1:0]       r_state;
   logic [c_CCW-1:0] r_col_cnt;
   logic [RW-1:0]    r_row_cnt;
   logic             r_win_valid;

   logic             w_src_ready;
   logic             w_accept;
   logic             w_consume;
   logic             w_row_end;

   always_comb begin
      w_src_ready = 1'b0;
      case (r_state)
         c_ST_FILL:  w_src_ready = 1'b1;
         c_ST_SLIDE: w_src_ready = (r_col_cnt < c_COL_MAX) && (!r_win_valid || win_ready);
         default:    w_src_ready = 1'b0;
      endcase
   end

   assign w_accept  = src_valid & w_src_ready;
   assign w_consume = r_win_valid & win_ready;
   assign w_row_end = w_consume && (r_col_cnt == c_COL_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_col_cnt   <= '0;
         r_row_cnt   <= '0;
         r_win_valid <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (start) begin
                  r_state   <= c_ST_FILL;
                  r_col_cnt <= '0;
                  r_row_cnt <= '0;
               end
            end
            c_ST_FILL: begin
               if (w_accept) begin
                  r_col_cnt <= r_col_cnt + c_CCW'(1);
                  if (r_col_cnt == c_COL_LFILL) begin
                     r_state     <= c_ST_SLIDE;
                     r_win_valid <= 1'b1;
                  end
               end
            end
            c_ST_SLIDE: begin
               // An accept while a window is consumed keeps win_valid high
               if (w_accept) begin
                  r_col_cnt   <= r_col_cnt + c_CCW'(1);
                  r_win_valid <= 1'b1;
               end else if (w_row_end) begin
                  r_win_valid <= 1'b0;
                  r_col_cnt   <= '0;
                  if (r_row_cnt == c_ROW_LAST) begin
                     r_state <= c_ST_DONE;
                  end else begin
                     r_row_cnt <= r_row_cnt + RW'(1);
                     r_state   <= c_ST_FILL;
                  end
               end else if (w_consume) begin
                  r_win_valid <= 1'b0;
               end
            end
            c_ST_DONE: r_state <= c_ST_IDLE;
            default:   r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign src_ready = w_src_ready;
   assign ifm_read  = w_accept;
   assign ifm_input = src_data;
   assign win_valid = r_win_valid;
   assign win_col   = r_win_valid ? CW'(r_col_cnt - c_COL_WIN) : '0;
   assign win_row   = r_win_valid ? r_row_cnt : '0;
   assign busy      = (r_state == c_ST_FILL) || (r_state == c_ST_SLIDE);
   assign done      = (r_state == c_ST_DONE);

`ifdef IFM_CTRL_PERF_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if ((r_state == c_ST_IDLE) && start) begin
         r_stall_cnt <= '0;
      end else if (r_win_valid && !win_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
